// File: rtl/timer_dev.sv
// Memory-mapped timer peripheral: bus responder with CTRL/COUNT/COMPARE/STATUS/PRESCALE
// registers, a prescaled 32-bit up-counter and a level interrupt on compare match.
module timer_dev #(
    parameter logic [63:0] BASE    = 64'h0000_0000_0001_0000,
    parameter int          LATENCY = 2,
    parameter logic [7:0]  DEV_ID  = 8'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        txe,
    output logic        txs,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] value,
    output logic [31:0] out,
    input  logic [63:0] addr,
    output logic        err,
    output logic        irq,
    output logic [7:0]  irq_dev_id
);

    localparam int                DATA_W    = 32;
    localparam int                WCNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(LATENCY - 1);
    localparam logic [63:0]       LIMIT     = BASE + 64'h14;

    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_COUNT    = 3'd1;
    localparam logic [2:0] IDX_COMPARE  = 3'd2;
    localparam logic [2:0] IDX_STATUS   = 3'd3;
    localparam logic [2:0] IDX_PRESCALE = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   accept, access;

    logic [WCNT_W-1:0] wcnt;

    logic              rd_p0, wr_p0;
    logic [63:0]       addr_p0;
    logic [DATA_W-1:0] val_p0;

    logic              req_err;
    logic [2:0]        reg_idx;
    logic              wr_ok;
    logic              wr_ctrl, wr_count, wr_compare, wr_status, wr_prescale;
    logic [DATA_W-1:0] rdata;

    logic [2:0]        ctrl;
    logic [DATA_W-1:0] count, compare, prescale, pcnt;
    logic              pend;
    logic              en, ie, autoreload;
    logic              tick, match;

    logic [DATA_W-1:0] out_p1;
    logic              err_p1;
    logic              irq_r;

    // Bus handshake FSM
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (txe) begin
                    state_nxt = BUSY;
                    accept    = 1'b1;
                end
            end
            BUSY: begin
                if (wcnt == '0) begin
                    state_nxt = DONE;
                    access    = 1'b1;
                end
            end
            DONE:    state_nxt = RELEASE;
            RELEASE: if (!txe) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
        end else if (accept) begin
            wcnt <= WAIT_INIT;
        end else if (state == BUSY && wcnt != '0) begin
            wcnt <= wcnt - 1'b1;
        end
    end

    // Stage p0: request captured at accept, held until the access cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_p0   <= read;
            wr_p0   <= write;
            addr_p0 <= addr;
            val_p0  <= value;
        end
    end

    // BASE is 32-byte aligned, so in-range addresses index registers by bits [4:2].
    always_comb begin
        req_err = (rd_p0 == wr_p0) || (addr_p0[1:0] != 2'b00) ||
                  (addr_p0 < BASE) || (addr_p0 >= LIMIT);
        reg_idx = addr_p0[4:2];
        wr_ok   = access && !req_err && wr_p0;
    end

    assign wr_ctrl     = wr_ok && (reg_idx == IDX_CTRL);
    assign wr_count    = wr_ok && (reg_idx == IDX_COUNT);
    assign wr_compare  = wr_ok && (reg_idx == IDX_COMPARE);
    assign wr_status   = wr_ok && (reg_idx == IDX_STATUS);
    assign wr_prescale = wr_ok && (reg_idx == IDX_PRESCALE);

    always_comb begin
        rdata = '0;
        case (reg_idx)
            IDX_CTRL:     rdata = {29'd0, ctrl};
            IDX_COUNT:    rdata = count;
            IDX_COMPARE:  rdata = compare;
            IDX_STATUS:   rdata = {31'd0, pend};
            IDX_PRESCALE: rdata = prescale;
            default:      rdata = '0;
        endcase
    end

    assign en         = ctrl[0];
    assign ie         = ctrl[1];
    assign autoreload = ctrl[2];
    assign tick       = en && (pcnt == prescale);
    assign match      = tick && (count == compare);

    // Register file and counter; bus writes take priority over counting,
    // except that a match always leaves PEND set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl     <= '0;
            count    <= '0;
            compare  <= 32'hFFFF_FFFF;
            pend     <= 1'b0;
            prescale <= '0;
            pcnt     <= '0;
            irq_r    <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= val_p0[2:0];

            if (wr_count)   count <= val_p0;
            else if (tick)  count <= (match && autoreload) ? '0 : count + 32'd1;

            if (wr_compare) compare <= val_p0;

            if (match)                       pend <= 1'b1;
            else if (wr_status && val_p0[0]) pend <= 1'b0;

            if (wr_prescale) begin
                prescale <= val_p0;
                pcnt     <= '0;
            end else if (en) begin
                pcnt <= (pcnt == prescale) ? '0 : pcnt + 32'd1;
            end

            irq_r <= pend & ie;
        end
    end

    // Stage p1: response captured in the access cycle, presented during DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            out_p1 <= '0;
            err_p1 <= 1'b0;
        end else if (access) begin
            err_p1 <= req_err;
            if (req_err)    out_p1 <= '0;
            else if (rd_p0) out_p1 <= rdata;
        end
    end

    assign txs        = (state == DONE);
    assign err        = (state == DONE) && err_p1;
    assign out        = out_p1;
    assign irq        = irq_r;
    assign irq_dev_id = irq_r ? DEV_ID : 8'd0;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: register-access vector table plus hand-written
// sequences for compare match, W1C races, prescaling, txe hold and reset.
module tb_timer_dev;

    localparam logic [63:0] BASE       = 64'h0000_0000_0001_0000;
    localparam logic [63:0] A_CTRL     = BASE;
    localparam logic [63:0] A_COUNT    = BASE + 64'h4;
    localparam logic [63:0] A_COMPARE  = BASE + 64'h8;
    localparam logic [63:0] A_STATUS   = BASE + 64'hC;
    localparam logic [63:0] A_PRESCALE = BASE + 64'h10;

    logic        clk = 1'b0;
    logic        rst, txe, read, write;
    logic [31:0] value, out;
    logic [63:0] addr;
    logic        txs, err, irq;
    logic [7:0]  irq_dev_id;

    int tests = 0;
    int fails = 0;

    logic mon_en   = 1'b0;
    logic irq_drop = 1'b0;

    always #5 clk = ~clk;

    timer_dev #(.BASE(BASE), .LATENCY(2), .DEV_ID(8'd1)) dut (
        .clk(clk), .rst(rst), .txe(txe), .txs(txs), .read(read), .write(write),
        .value(value), .out(out), .addr(addr), .err(err), .irq(irq),
        .irq_dev_id(irq_dev_id)
    );

    always @(negedge clk) if (mon_en && !irq) irq_drop <= 1'b1;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [63:0] addr;
        logic [31:0] val;
        logic [31:0] exp_out;
        logic        exp_err;
        logic        chk_out;
    } vec_t;

    vec_t tbl [24];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bus(input logic r, input logic w, input logic [63:0] a, input logic [31:0] v,
                       output logic [31:0] o, output logic e, output int lat);
        @(negedge clk);
        txe = 1'b1; read = r; write = w; addr = a; value = v;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (txs) break;
        end
        if (!txs) lat = 99;
        o = out;
        e = err;
        txe = 1'b0; read = 1'b0; write = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [63:0] a, input logic [31:0] v);
        logic [31:0] o;
        logic        e;
        int          l;
        bus(1'b0, 1'b1, a, v, o, e, l);
        check("write latency", 64'(l), 64'd3);
        check("write err", 64'(e), 64'd0);
    endtask

    task automatic rd(input logic [63:0] a, output logic [31:0] d);
        logic e;
        int   l;
        bus(1'b1, 1'b0, a, 32'h0, d, e, l);
        check("read latency", 64'(l), 64'd3);
        check("read err", 64'(e), 64'd0);
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (irq) break;
        end
        if (!irq) n = 99;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d, o;
        logic        e;
        int          l, n, pulses;

        tbl[0]  = '{1'b1, 1'b0, A_CTRL,        32'h0,         32'h0,         1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, A_COMPARE,     32'h0,         32'hFFFF_FFFF, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, A_COUNT,       32'h0,         32'h0,         1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, A_STATUS,      32'h0,         32'h0,         1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, A_PRESCALE,    32'h0,         32'h0,         1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, A_COUNT,       32'h0000_1234, 32'h0,         1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, A_COUNT,       32'h0,         32'h0000_1234, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, A_CTRL,        32'hFFFF_FFFC, 32'h0,         1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, A_CTRL,        32'h0,         32'h4,         1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, A_CTRL,        32'h0,         32'h0,         1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, A_PRESCALE,    32'h7,         32'h0,         1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, A_PRESCALE,    32'h0,         32'h7,         1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, A_PRESCALE,    32'h0,         32'h0,         1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, BASE + 64'h2,  32'h0,         32'h0,         1'b1, 1'b1};
        tbl[14] = '{1'b1, 1'b0, BASE + 64'h14, 32'h0,         32'h0,         1'b1, 1'b1};
        tbl[15] = '{1'b1, 1'b1, A_COUNT,       32'h0000_DEAD, 32'h0,         1'b1, 1'b1};
        tbl[16] = '{1'b0, 1'b0, A_COUNT,       32'h0000_BEEF, 32'h0,         1'b1, 1'b1};
        tbl[17] = '{1'b0, 1'b1, BASE - 64'h4,  32'h1,         32'h0,         1'b1, 1'b1};
        tbl[18] = '{1'b0, 1'b1, BASE + 64'h16, 32'h5,         32'h0,         1'b1, 1'b1};
        tbl[19] = '{1'b1, 1'b0, BASE + 64'h1C, 32'h0,         32'h0,         1'b1, 1'b1};
        tbl[20] = '{1'b1, 1'b0, A_COUNT,       32'h0,         32'h0000_1234, 1'b0, 1'b1};
        tbl[21] = '{1'b0, 1'b1, A_STATUS,      32'h1,         32'h0,         1'b0, 1'b0};
        tbl[22] = '{1'b1, 1'b0, A_STATUS,      32'h0,         32'h0,         1'b0, 1'b1};
        tbl[23] = '{1'b1, 1'b0, A_CTRL,        32'h0,         32'h0,         1'b0, 1'b1};

        rst = 1'b1; txe = 1'b0; read = 1'b0; write = 1'b0; addr = '0; value = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset txs", 64'(txs), 64'd0);
        check("reset err", 64'(err), 64'd0);
        check("reset out", 64'(out), 64'd0);
        check("reset irq", 64'(irq), 64'd0);
        check("reset irq_dev_id", 64'(irq_dev_id), 64'd0);

        for (int i = 0; i < 24; i++) begin
            bus(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].val, o, e, l);
            check($sformatf("vec%0d latency", i), 64'(l), 64'd3);
            check($sformatf("vec%0d err", i), 64'(e), 64'(tbl[i].exp_err));
            if (tbl[i].chk_out) check($sformatf("vec%0d out", i), 64'(o), 64'(tbl[i].exp_out));
        end

        // Compare match at 5 with prescale 0
        wr(A_COUNT, 32'd0);
        wr(A_COMPARE, 32'd5);
        wr(A_PRESCALE, 32'd0);
        wr(A_CTRL, 32'd3);
        wait_irq(n);
        check("match irq delay", 64'(n), 64'd5);
        check("match irq_dev_id", 64'(irq_dev_id), 64'd1);
        rd(A_COUNT, d);
        check("count past match >= 6", 64'(d >= 32'd6), 64'd1);
        rd(A_STATUS, d);
        check("pend after match", 64'(d), 64'd1);

        wr(A_STATUS, 32'd1);
        check("irq after w1c", 64'(irq), 64'd0);
        check("irq_dev_id after w1c", 64'(irq_dev_id), 64'd0);
        rd(A_STATUS, d);
        check("pend after w1c", 64'(d), 64'd0);

        // COMPARE=0 with autoreload matches on every tick, so any W1C races a set
        wr(A_CTRL, 32'd0);
        wr(A_COUNT, 32'd0);
        wr(A_COMPARE, 32'd0);
        wr(A_CTRL, 32'd7);
        check("irq continuous match", 64'(irq), 64'd1);
        mon_en = 1'b1;
        wr(A_STATUS, 32'd1);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check("irq stays high on w1c race", 64'(irq_drop), 64'd0);
        rd(A_STATUS, d);
        check("pend kept on w1c race", 64'(d), 64'd1);
        wr(A_CTRL, 32'd0);
        wr(A_STATUS, 32'd1);
        rd(A_STATUS, d);
        check("pend cleared when stopped", 64'(d), 64'd0);

        // Prescale 2: count steps every 3 cycles, match at 3 reloads to 0
        wr(A_COUNT, 32'd0);
        wr(A_COMPARE, 32'd3);
        wr(A_PRESCALE, 32'd2);
        wr(A_CTRL, 32'd7);
        check("irq low before prescaled match", 64'(irq), 64'd0);
        wait_irq(n);
        check("prescaled match irq delay", 64'(n), 64'd11);
        rd(A_COUNT, d);
        check("autoreload count <= 3", 64'(d <= 32'd3), 64'd1);
        rd(A_STATUS, d);
        check("pend after prescaled match", 64'(d), 64'd1);

        // txe held high long after txs
        wr(A_CTRL, 32'd0);
        @(negedge clk);
        txe = 1'b1; read = 1'b1; addr = A_COMPARE;
        pulses = 0;
        repeat (13) begin
            @(negedge clk);
            if (txs) pulses++;
        end
        check("single txs with txe held", 64'(pulses), 64'd1);
        check("out held after done", 64'(out), 64'd3);
        txe = 1'b0; read = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while BUSY drops the access and restores every register
        wr(A_CTRL, 32'd3);
        @(negedge clk);
        txe = 1'b1; read = 1'b1; addr = A_CTRL;
        @(negedge clk);
        rst = 1'b1; txe = 1'b0; read = 1'b0;
        @(negedge clk);
        check("txs in reset", 64'(txs), 64'd0);
        check("irq after reset", 64'(irq), 64'd0);
        check("out after reset", 64'(out), 64'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (txs) pulses++;
        end
        check("no txs after dropped access", 64'(pulses), 64'd0);
        rd(A_CTRL, d);     check("ctrl after reset", 64'(d), 64'd0);
        rd(A_COUNT, d);    check("count after reset", 64'(d), 64'd0);
        rd(A_COMPARE, d);  check("compare after reset", 64'(d), 64'hFFFF_FFFF);
        rd(A_STATUS, d);   check("status after reset", 64'(d), 64'd0);
        rd(A_PRESCALE, d); check("prescale after reset", 64'(d), 64'd0);

        // txe still high across reset is served as a fresh request
        @(negedge clk);
        txe = 1'b1; read = 1'b1; addr = A_COMPARE;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("txs during reset with txe", 64'(txs), 64'd0);
        rst = 1'b0;
        l = 0;
        while (l < 20) begin
            @(negedge clk);
            l++;
            if (txs) break;
        end
        if (!txs) l = 99;
        check("fresh request latency after reset", 64'(l), 64'd3);
        check("fresh request out", 64'(out), 64'hFFFF_FFFF);
        check("fresh request err", 64'(err), 64'd0);
        txe = 1'b0; read = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
